// File: rtl/mac_sequencer.sv
// Control sequencer for one MAC lane: handshakes operand pairs, launches the
// multiplier, strobes the two-phase accumulator and tracks completed pairs.
module mac_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mul_start,
    input  logic             mul_done,
    output logic             add,
    output logic             acc_clr,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_IN,
        MUL_GO,
        MUL_WAIT,
        ADD_HI,
        ADD_LO,
        DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] count_reg, count_next;
    logic             zero_job;

    logic in_ready_reg, in_ready_next;
    logic mul_start_reg, mul_start_next;
    logic add_reg, add_next;
    logic acc_clr_reg, acc_clr_next;
    logic busy_reg, busy_next;
    logic done_reg, done_next;

    // State, bookkeeping and output flops; outputs are registered copies of
    // the decode of the upcoming state so `add` never glitches downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b0;
            mul_start_reg <= 1'b0;
            add_reg       <= 1'b0;
            acc_clr_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            count_reg     <= count_next;
            in_ready_reg  <= in_ready_next;
            mul_start_reg <= mul_start_next;
            add_reg       <= add_next;
            acc_clr_reg   <= acc_clr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        len_next   = len_reg;
        count_next = count_reg;
        zero_job   = 1'b0;
        // Abort wins over everything while a job is active; count is left alone.
        if (abort && state_reg != IDLE && state_reg != DONE) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        len_next   = length;
                        count_next = '0;
                        if (length == '0) begin
                            state_next = DONE;
                            zero_job   = 1'b1;
                        end else begin
                            state_next = CLEAR;
                        end
                    end
                end
                CLEAR:    state_next = WAIT_IN;
                WAIT_IN:  if (in_valid) state_next = MUL_GO;
                MUL_GO:   state_next = MUL_WAIT;
                MUL_WAIT: if (mul_done) state_next = ADD_HI;
                ADD_HI:   state_next = ADD_LO;
                ADD_LO: begin
                    count_next = count_reg + LEN_W'(1);
                    state_next = (count_next == len_reg) ? DONE : WAIT_IN;
                end
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_next  = (state_next == WAIT_IN);
        mul_start_next = (state_next == MUL_GO);
        add_next       = (state_next == ADD_HI);
        // A zero-length job still clears the accumulator, in its DONE cycle.
        acc_clr_next   = (state_next == CLEAR) || zero_job;
        busy_next      = (state_next != IDLE) && (state_next != DONE);
        done_next      = (state_next == DONE);
    end

    assign in_ready  = in_ready_reg;
    assign mul_start = mul_start_reg;
    assign add       = add_reg;
    assign acc_clr   = acc_clr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: table of jobs with expected timing, a scoreboard of
// per-job expectations, plus hand-written reset sequences.
module tb_mac_sequencer;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] length = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic             mul_done = 1'b0;
    logic             in_ready, mul_start, add, acc_clr, busy, done;
    logic [LEN_W-1:0] count;

    always #5 clk = ~clk;

    mac_sequencer #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .add       (add),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    typedef struct {
        int len;
        int k;
        int stall;
        int abort_add;
        bit spurious;
        int exp_done;
        int exp_count;
    } vec_t;

    typedef struct {
        int done_cyc;
        int count;
        int n_mul;
        int n_add;
        int n_ready;
        int n_clr;
        int clr_cyc;
        int busy_ever;
        int n_viol;
    } res_t;

    res_t sb_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input int idx, input vec_t v);
        res_t e, o, got;
        int   c, ms, stall_left, last_add, aborted;
        bit   finished;
        e.done_cyc  = v.exp_done;
        e.count     = v.exp_count;
        e.n_mul     = (v.abort_add > 0) ? v.abort_add : v.len;
        e.n_add     = e.n_mul;
        e.n_ready   = (v.abort_add > 0) ? v.abort_add : v.len + v.stall;
        e.n_clr     = 1;
        e.clr_cyc   = 1;
        e.busy_ever = (v.len != 0) ? 1 : 0;
        e.n_viol    = 0;
        sb_q.push_back(e);
        o.done_cyc = -1; o.count = -1; o.n_mul = 0; o.n_add = 0; o.n_ready = 0;
        o.n_clr = 0; o.clr_cyc = -1; o.busy_ever = 0; o.n_viol = 0;
        c = 0; ms = -100; stall_left = v.stall; last_add = -100; aborted = 0; finished = 0;
        @(negedge clk);
        start  = 1'b1;
        length = v.len[LEN_W-1:0];
        while (!finished && c < 3000) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            start    = 1'b0;
            length   = LEN_W'($urandom);
            abort    = 1'b0;
            mul_done = 1'b0;
            if (busy) o.busy_ever = 1;
            if (acc_clr) begin
                o.n_clr++;
                if (o.clr_cyc < 0) o.clr_cyc = c;
            end
            if (in_ready) o.n_ready++;
            if (mul_start) begin
                o.n_mul++;
                ms = c;
            end
            if (add) begin
                o.n_add++;
                if (last_add == c - 1) o.n_viol++;
                else if (last_add > 0 && c - last_add - 1 < 4) o.n_viol++;
                last_add = c;
            end
            if (in_ready && (mul_start || add)) o.n_viol++;
            if (done) begin
                o.done_cyc = c;
                o.count    = int'(count);
                finished   = 1;
            end else if (aborted != 0 && !busy) begin
                check($sformatf("v%0d_abort_add_low", idx), int'(add), 0);
                o.count  = int'(count);
                finished = 1;
            end
            if (in_ready && stall_left > 0) begin
                in_valid = 1'b0;
                stall_left--;
            end else begin
                in_valid = 1'b1;
            end
            if (c == ms + v.k) mul_done = 1'b1;
            if (v.spurious && (in_ready || mul_start)) mul_done = 1'b1;
            if (v.spurious && busy) start = 1'b1;
            if (v.abort_add > 0 && add && o.n_add == v.abort_add) begin
                abort   = 1'b1;
                aborted = 1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        mul_done = 1'b0;
        check($sformatf("v%0d_finished", idx), int'(finished), 1);
        check($sformatf("v%0d_sb_nonempty", idx), sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check($sformatf("v%0d_done_cycle", idx), o.done_cyc, got.done_cyc);
            check($sformatf("v%0d_count", idx), o.count, got.count);
            check($sformatf("v%0d_mul_starts", idx), o.n_mul, got.n_mul);
            check($sformatf("v%0d_adds", idx), o.n_add, got.n_add);
            check($sformatf("v%0d_ready_cycles", idx), o.n_ready, got.n_ready);
            check($sformatf("v%0d_clr_pulses", idx), o.n_clr, got.n_clr);
            check($sformatf("v%0d_clr_cycle", idx), o.clr_cyc, got.clr_cyc);
            check($sformatf("v%0d_busy_seen", idx), o.busy_ever, got.busy_ever);
            check($sformatf("v%0d_protocol_viol", idx), o.n_viol, got.n_viol);
        end
        $display("[TB] job %0d len=%0d k=%0d stall=%0d abort_at=%0d done_cyc=%0d count=%0d",
                 idx, v.len, v.k, v.stall, v.abort_add, o.done_cyc, o.count);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];
    bit   reached;

    initial begin
        tbl[0] = '{3,   2, 0, 0, 1'b0, 20,   3};
        tbl[1] = '{2,   2, 0, 0, 1'b0, 14,   2};
        tbl[2] = '{2,   2, 5, 0, 1'b0, 19,   2};
        tbl[3] = '{0,   2, 0, 0, 1'b0, 1,    0};
        tbl[4] = '{4,   2, 0, 2, 1'b0, -1,   1};
        tbl[5] = '{3,   2, 0, 0, 1'b0, 20,   3};
        tbl[6] = '{3,   2, 0, 0, 1'b1, 20,   3};
        tbl[7] = '{1,   1, 0, 0, 1'b0, 7,    1};
        tbl[8] = '{5,   3, 0, 0, 1'b0, 37,   5};
        tbl[9] = '{255, 1, 0, 0, 1'b0, 1277, 255};

        // Reset held with random inputs: every output must stay at zero.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start    = 1'($urandom);
            length   = LEN_W'($urandom);
            abort    = 1'($urandom);
            in_valid = 1'($urandom);
            mul_done = 1'($urandom);
        end
        @(negedge clk);
        check("reset_outputs", int'({in_ready, mul_start, add, acc_clr, busy, done}), 0);
        check("reset_count", int'(count), 0);
        $display("[TB] reset held: outs=%b count=%0d",
                 {in_ready, mul_start, add, acc_clr, busy, done}, count);
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; mul_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_job(i, tbl[i]);

        // Reset asserted mid-job while add is high: must drop without a clock edge.
        @(negedge clk);
        start = 1'b1; length = LEN_W'(3); in_valid = 1'b1; mul_done = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clk);
            if (add) reached = 1'b1;
        end
        check("midreset_reached_add", int'(reached), 1);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_async_add", int'(add), 0);
        check("midreset_async_busy", int'(busy), 0);
        check("midreset_async_outs", int'({in_ready, mul_start, acc_clr, done}), 0);
        $display("[TB] mid-job reset: add=%b busy=%b count=%0d", add, busy, count);
        @(negedge clk);
        in_valid = 1'b0; mul_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        run_job(10, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control FSM for one MAC lane: sequences a multiply-then-accumulate loop over a vector of `length` operand pairs. It accepts operand pairs through a valid/ready handshake and starts an external sequential multiplier. It then drives the two-phase `add` strobe of the 20-bit accumulator (capture on rising edge, sum latch on falling edge) and clears the accumulator at the start of each job. It sits between the operand source and the multiplier/accumulator datapath and owns no arithmetic.

## Interface
- `LEN_W`, default 8: width of `length` and `count`. Max vector length is 2^LEN_W − 1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state and outputs to reset values.
- `start` in 1: job request, sampled in IDLE only.
- `length` in LEN_W: number of operand pairs, sampled with `start`.
- `abort` in 1: synchronous job cancel.
- `in_valid` in 1: operand pair available at the source.
- `in_ready` out 1: sequencer accepts a pair this cycle.
- `mul_start` out 1: one-cycle pulse that launches the multiplier.
- `mul_done` in 1: multiplier product valid; sampled in MUL_WAIT only.
- `add` out 1: accumulator strobe; used as a clock downstream.
- `acc_clr` out 1: accumulator clear, one-cycle pulse.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle completion pulse.
- `count` out LEN_W: pairs fully accumulated in the current job.

## Operation
- All outputs are registered (Moore, decoded from state flops) and glitch-free; `add` especially must come straight from a flop.
- Reset values: `in_ready`, `mul_start`, `add`, `acc_clr`, `busy` and `done` = 0; `count` = 0; state = IDLE.
- States: IDLE, CLEAR, WAIT_IN, MUL_GO, MUL_WAIT, ADD_HI, ADD_LO, DONE.
- IDLE → CLEAR when `start`=1 and `length`≠0. The sequencer latches `length` and sets `count`=0.
- IDLE, `start`=1 and `length`=0 → DONE. `acc_clr` and `done` both pulse in that cycle; accumulator result is 0.
- CLEAR: `acc_clr`=1 and `busy`=1 → WAIT_IN.
- WAIT_IN: `in_ready`=1. On `in_valid`=1 (handshake) → MUL_GO. Otherwise the sequencer stays, with no timeout.
- MUL_GO: `mul_start`=1 for exactly one cycle → MUL_WAIT. Any `mul_done` in this cycle is ignored.
- MUL_WAIT: on `mul_done`=1 → ADD_HI.
- ADD_HI: `add`=1 for one cycle → ADD_LO.
- ADD_LO: `add`=0 and `count` increments.
  - If the new `count` equals the latched length → DONE.
  - Otherwise → WAIT_IN.
- DONE: `done`=1 and `busy`=0 → IDLE.
- `busy`=1 in every state except IDLE and DONE.
- `start` is ignored while `busy`=1. `length` changes after the start cycle have no effect.
- `abort`=1 in any state other than IDLE/DONE → IDLE on the next edge.
  - No `done` pulse; `count` holds its value.
  - `add` returns to 0. If the abort arrives in ADD_HI, the resulting falling edge completes that element's accumulation, but `count` is not incremented.
- `abort` has priority over every other transition. It is ignored in IDLE and DONE.
- `count` holds after DONE until the next accepted `start`.

## Timing
- Edge 0 samples `start`. CLEAR occupies cycle 1. First WAIT_IN is cycle 2.
- Per element, with `in_valid` already high and `mul_done` arriving k≥1 cycles after the `mul_start` cycle: WAIT_IN (1) + MUL_GO (1) + MUL_WAIT (k) + ADD_HI (1) + ADD_LO (1) = k+4 cycles.
- Job of N pairs with stalls = 0: `done` is high in cycle 2 + N·(k+4).
- `add` high phase is exactly 1 cycle. Low phase before the next rising edge is at least 4 cycles.
- `in_ready` is never high in the same cycle as `mul_start` or `add`.
- `reset` asserted mid-job: outputs go to reset values immediately and asynchronously. `add` falling here is permitted.

## Test plan
- Reset: hold `reset`=0 with random inputs → all outputs 0 and `count`=0. Release, then `start`=1, `length`=3 → `acc_clr` pulses in cycle 1.
- Nominal: `length`=3, `in_valid` tied 1, `mul_done` returned 2 cycles after each `mul_start` → 3 `mul_start` pulses, 3 `add` pulses, `done` in cycle 20, `count`=3.
- Backpressure: `length`=2, `in_valid` low for 5 cycles in the first WAIT_IN → `in_ready` stays 1 throughout and `done` is delayed by exactly 5 cycles.
- Zero length: `start`=1, `length`=0 → `acc_clr`=1 and `done`=1 in the next cycle, `busy` never 1, no `add`.
- Abort: `length`=4, `abort` pulsed during the second ADD_HI → `add` falls on the next edge, state IDLE, `count`=1, no `done`. A new `start` then works normally.
- Spurious inputs: `start` pulsed while busy and `mul_done` asserted in MUL_GO and WAIT_IN → no effect on sequence or cycle counts.
